// File: rtl/star_box_writer_pkg.sv
// Shared sizes, colour constant and FSM encoding for the star box writer
// and its address helper.
package star_box_writer_pkg;

  localparam int X_SZ    = 3;
  localparam int Y_SZ    = 3;
  localparam int ADDR_SZ = 6;
  localparam int COL_SZ  = 3;
  localparam int WIDTH   = 6;
  localparam int HEIGHT  = 6;

  // Black doubles as the threshold colour of the extent finder.
  localparam logic [COL_SZ-1:0] COL_BLACK = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/star_box_writer_if.sv
// Request/RAM-write bundle between extent-finder control, the box writer
// and the image RAM write port.
interface star_box_writer_if;
  import star_box_writer_pkg::*;

  logic                start;
  logic                fill;
  logic [X_SZ-1:0]     left;
  logic [X_SZ-1:0]     right;
  logic [Y_SZ-1:0]     top;
  logic [Y_SZ-1:0]     bottom;
  logic [COL_SZ-1:0]   colour;
  logic [ADDR_SZ-1:0]  address;
  logic [COL_SZ-1:0]   data;
  logic                wren;
  logic                busy;
  logic                done;
  logic                err;

  modport master (
    output start, fill, left, right, top, bottom, colour,
    input  address, data, wren, busy, done, err
  );

  modport slave (
    input  start, fill, left, right, top, bottom, colour,
    output address, data, wren, busy, done, err
  );

endinterface

// File: rtl/star_box_writer_addr_calc.sv
// Combinational pixel address: y*WIDTH + x with zero-extended operands.
module box_addr_calc
  import star_box_writer_pkg::*;
(
  input  logic [X_SZ-1:0]    i_x,
  input  logic [Y_SZ-1:0]    i_y,
  output logic [ADDR_SZ-1:0] o_addr
);

  logic [ADDR_SZ-1:0] w_x;
  logic [ADDR_SZ-1:0] w_y;

  assign w_x = ADDR_SZ'(i_x);
  assign w_y = ADDR_SZ'(i_y);

  generate
    if (WIDTH == 6) begin : g_shift_add
      // 6 = 4 + 2, so the row offset is two shifts and an add.
      assign o_addr = (w_y << 2) + (w_y << 1) + w_x;
    end else begin : g_mult
      assign o_addr = (w_y * ADDR_SZ'(WIDTH)) + w_x;
    end
  endgenerate

endmodule

// File: rtl/star_box_writer.sv
// Writes a star's bounding box (outline or solid fill) into the image RAM,
// one pixel per clock in raster order, then pulses done.
module star_box_writer
  import star_box_writer_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  star_box_writer_if.slave   bus
);

  state_e              r_state;
  state_e              w_next;
  logic [X_SZ-1:0]     r_left;
  logic [X_SZ-1:0]     r_right;
  logic [Y_SZ-1:0]     r_top;
  logic [Y_SZ-1:0]     r_bottom;
  logic                r_fill;
  logic [COL_SZ-1:0]   r_colour;
  logic [X_SZ-1:0]     r_x;
  logic [Y_SZ-1:0]     r_y;
  logic                r_err;

  logic                w_valid;
  logic                w_last;
  logic                w_edge;
  logic [ADDR_SZ-1:0]  w_pix_addr;
  logic [ADDR_SZ-1:0]  w_address;
  logic [COL_SZ-1:0]   w_data;
  logic                w_wren;
  logic                w_busy;
  logic                w_done;
  logic                w_err;

  box_addr_calc u_addr (
    .i_x    (r_x),
    .i_y    (r_y),
    .o_addr (w_pix_addr)
  );

  // Bounds checked here guarantee the counters can never leave the image.
  assign w_valid = (bus.left <= bus.right) && (bus.top <= bus.bottom) &&
                   (int'(bus.right) < WIDTH) && (int'(bus.bottom) < HEIGHT);
  assign w_last  = (r_x == r_right) && (r_y == r_bottom);
  assign w_edge  = r_fill || (r_x == r_left) || (r_x == r_right) ||
                   (r_y == r_top) || (r_y == r_bottom);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next    = r_state;
    w_address = '0;
    w_data    = COL_BLACK;
    w_wren    = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    w_err     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_next = w_valid ? ST_SCAN : ST_DONE;
      end
      ST_SCAN: begin
        w_busy    = 1'b1;
        w_address = w_pix_addr;
        w_data    = r_colour;
        w_wren    = w_edge;
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_err  = r_err;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_left   <= '0;
      r_right  <= '0;
      r_top    <= '0;
      r_bottom <= '0;
      r_fill   <= 1'b0;
      r_colour <= COL_BLACK;
      r_x      <= '0;
      r_y      <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_left   <= bus.left;
            r_right  <= bus.right;
            r_top    <= bus.top;
            r_bottom <= bus.bottom;
            r_fill   <= bus.fill;
            r_colour <= bus.colour;
            r_x      <= bus.left;
            r_y      <= bus.top;
            r_err    <= !w_valid;
          end
        end
        ST_SCAN: begin
          if (r_x == r_right) begin
            r_x <= r_left;
            r_y <= r_y + Y_SZ'(1);
          end else begin
            r_x <= r_x + X_SZ'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.address = w_address;
  assign bus.data    = w_data;
  assign bus.wren    = w_wren;
  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.err     = w_err;

endmodule
